// File: rtl/maze_mem_arbiter_if.sv
// One requester port of the maze memory arbiter (host loader or solver controller).
// The requester holds req until gnt; rvalid marks the cycle in which shared rdata is valid.
interface maze_mem_arbiter_if #(
    parameter int AW = 4
);
    logic          req;
    logic          we;
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    logic          din;
    logic          gnt;
    logic          rvalid;

    modport master (output req, we, x, y, din, input gnt, rvalid);
    modport slave  (input req, we, x, y, din, output gnt, rvalid);
endinterface

// File: rtl/maze_mem_arbiter.sv
// Arbitrates the single-port N x N 1-bit maze RAM between host and solver; includes a bulk clear.
// Define ARB_RR_EN for round-robin host/solver arbitration (default build: host over solver).
//
// state | meaning
// IDLE  | no access in flight, memory signals quiet
// GNT_H | host access presented to memory, host gnt high
// GNT_S | solver access presented to memory, solver gnt high
// RESP  | read data from memory returned with rvalid
// CLEAR | writing 0 to one cell per cycle, row-major
module maze_mem_arbiter #(
    parameter int N  = 16,
    parameter int AW = 4
) (
    input  logic               clk,
    input  logic               reset,
    maze_mem_arbiter_if.slave  host,
    maze_mem_arbiter_if.slave  solver,
    output logic               rdata,
    output logic               err,
    input  logic               clear_start,
    output logic               clear_busy,
    output logic               clear_done,
    output logic [AW-1:0]      mem_x,
    output logic [AW-1:0]      mem_y,
    output logic               mem_we,
    output logic               mem_din,
    input  logic               mem_dout
);
    typedef enum logic [2:0] {IDLE, GNT_H, GNT_S, RESP, CLEAR} state_t;

    localparam logic [AW-1:0] LAST  = AW'(N - 1);
    localparam logic [AW:0]   LIMIT = (AW + 1)'(N);

    state_t state;
    logic   clear_pend;
    logic   rd_pend;
    logic   resp_oor;
    logic   h_oor;
    logic   s_oor;
    logic   pick_h;

    assign h_oor = ({1'b0, host.x} >= LIMIT) || ({1'b0, host.y} >= LIMIT);
    assign s_oor = ({1'b0, solver.x} >= LIMIT) || ({1'b0, solver.y} >= LIMIT);

`ifdef ARB_RR_EN
    logic rr_ptr;  // 0 favours host, 1 favours solver
    assign pick_h = host.req && (!solver.req || !rr_ptr);
`else
    assign pick_h = host.req;
`endif

    // Out-of-range reads report a wall.
    assign rdata = (state == RESP) && (resp_oor || mem_dout);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            clear_pend    <= 1'b0;
            rd_pend       <= 1'b0;
            resp_oor      <= 1'b0;
            host.gnt      <= 1'b0;
            host.rvalid   <= 1'b0;
            solver.gnt    <= 1'b0;
            solver.rvalid <= 1'b0;
            err           <= 1'b0;
            clear_busy    <= 1'b0;
            clear_done    <= 1'b0;
            mem_x         <= '0;
            mem_y         <= '0;
            mem_we        <= 1'b0;
            mem_din       <= 1'b0;
`ifdef ARB_RR_EN
            rr_ptr        <= 1'b0;
`endif
        end else begin
            host.gnt      <= 1'b0;
            host.rvalid   <= 1'b0;
            solver.gnt    <= 1'b0;
            solver.rvalid <= 1'b0;
            err           <= 1'b0;
            clear_done    <= 1'b0;
            if (clear_start && state != CLEAR)
                clear_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (clear_pend) begin
                        // A start arriving in this same cycle is absorbed by the clear now beginning.
                        state      <= CLEAR;
                        clear_pend <= 1'b0;
                        clear_busy <= 1'b1;
                        mem_we     <= 1'b1;
                        mem_din    <= 1'b0;
                        mem_x      <= '0;
                        mem_y      <= '0;
                    end else if (pick_h) begin
                        state    <= GNT_H;
                        host.gnt <= 1'b1;
                        mem_x    <= host.x;
                        mem_y    <= host.y;
                        mem_din  <= host.din;
                        mem_we   <= host.we && !h_oor;
                        err      <= h_oor;
                        resp_oor <= h_oor;
                        rd_pend  <= !host.we;
`ifdef ARB_RR_EN
                        rr_ptr   <= 1'b1;
`endif
                    end else if (solver.req) begin
                        state      <= GNT_S;
                        solver.gnt <= 1'b1;
                        mem_x      <= solver.x;
                        mem_y      <= solver.y;
                        mem_din    <= solver.din;
                        mem_we     <= solver.we && !s_oor;
                        err        <= s_oor;
                        resp_oor   <= s_oor;
                        rd_pend    <= !solver.we;
`ifdef ARB_RR_EN
                        rr_ptr     <= 1'b0;
`endif
                    end
                end
                GNT_H, GNT_S: begin
                    mem_x   <= '0;
                    mem_y   <= '0;
                    mem_we  <= 1'b0;
                    mem_din <= 1'b0;
                    if (rd_pend) begin
                        state <= RESP;
                        if (state == GNT_H)
                            host.rvalid <= 1'b1;
                        else
                            solver.rvalid <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    resp_oor <= 1'b0;
                    rd_pend  <= 1'b0;
                end
                CLEAR: begin
                    // mem_x/mem_y double as the clear counter.
                    if (mem_x == LAST && mem_y == LAST) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_x      <= '0;
                        mem_y      <= '0;
                    end else if (mem_x == LAST) begin
                        mem_x <= '0;
                        mem_y <= mem_y + AW'(1);
                    end else begin
                        mem_x <= mem_x + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Testbench for maze_mem_arbiter: scoreboard of expected grants/read responses/clear completions,
// popped by a monitor on the falling edge. A second N=10 instance covers out-of-range accesses.
module tb_maze_mem_arbiter;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    maze_mem_arbiter_if #(.AW(AW)) hb ();
    maze_mem_arbiter_if #(.AW(AW)) sb ();
    maze_mem_arbiter_if #(.AW(AW)) hb2 ();
    maze_mem_arbiter_if #(.AW(AW)) sb2 ();

    logic          rdata, err, clear_start, clear_busy, clear_done, mem_we, mem_din, mem_dout;
    logic [AW-1:0] mem_x, mem_y;
    logic          rdata2, err2, clear_start2, clear_busy2, clear_done2, mem_we2, mem_din2, mem_dout2;
    logic [AW-1:0] mem_x2, mem_y2;

    maze_mem_arbiter #(.N(16), .AW(AW)) dut (
        .clk(clk), .reset(reset), .host(hb), .solver(sb),
        .rdata(rdata), .err(err), .clear_start(clear_start), .clear_busy(clear_busy),
        .clear_done(clear_done), .mem_x(mem_x), .mem_y(mem_y), .mem_we(mem_we),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    maze_mem_arbiter #(.N(10), .AW(AW)) dut10 (
        .clk(clk), .reset(reset), .host(hb2), .solver(sb2),
        .rdata(rdata2), .err(err2), .clear_start(clear_start2), .clear_busy(clear_busy2),
        .clear_done(clear_done2), .mem_x(mem_x2), .mem_y(mem_y2), .mem_we(mem_we2),
        .mem_din(mem_din2), .mem_dout(mem_dout2)
    );

    // Memory models: 1-cycle synchronous read, zeroed during the initial reset only.
    logic mem1 [256];
    logic mem2 [256];
    always @(posedge clk) begin
        if (reset && cyc < 4) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 1'b0;
                mem2[i] <= 1'b0;
            end
        end else begin
            if (mem_we)  mem1[{mem_y, mem_x}]   <= mem_din;
            if (mem_we2) mem2[{mem_y2, mem_x2}] <= mem_din2;
        end
        mem_dout  <= mem1[{mem_y, mem_x}];
        mem_dout2 <= mem2[{mem_y2, mem_x2}];
    end

    typedef struct {
        bit           port;
        bit           we;
        bit           din;
        bit           err;
        logic [3:0]   x;
        logic [3:0]   y;
        int           cyc;
    } gnt_t;

    typedef struct {
        bit port;
        bit data;
        int cyc;
    } rv_t;

    gnt_t gnt_q [$];
    rv_t  rv_q  [$];
    int   done_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string msg);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    // Monitor
    gnt_t m_g;
    rv_t  m_r;
    int   m_d;
    int   busy_cnt = 0;
    int   clr_bad  = 0;
    initial forever begin
        @(negedge clk);
        if (reset) begin
            busy_cnt = 0;
            clr_bad  = 0;
        end else begin
            if (hb.gnt || sb.gnt) begin
                if (gnt_q.size() == 0) begin
                    fail("gnt_unexpected", "grant seen with nothing expected");
                end else begin
                    m_g = gnt_q.pop_front();
                    check("gnt_port", {hb.gnt, sb.gnt}, m_g.port ? 2'b01 : 2'b10);
                    check("gnt_cycle", cyc, m_g.cyc);
                    check("gnt_mem_we", mem_we, m_g.we);
                    check("gnt_err", err, m_g.err);
                    check("gnt_addr", {mem_y, mem_x}, {m_g.y, m_g.x});
                    if (m_g.we) check("gnt_din", mem_din, m_g.din);
                end
            end else if (err) begin
                fail("err_without_gnt", "err=1 expected 0");
            end
            if (hb.rvalid || sb.rvalid) begin
                if (rv_q.size() == 0) begin
                    fail("rvalid_unexpected", "rvalid seen with nothing expected");
                end else begin
                    m_r = rv_q.pop_front();
                    check("rv_port", {hb.rvalid, sb.rvalid}, m_r.port ? 2'b01 : 2'b10);
                    check("rv_rdata", rdata, m_r.data);
                    check("rv_cycle", cyc, m_r.cyc);
                end
            end
            if (clear_busy) begin
                if ({mem_y, mem_x} !== 8'(busy_cnt) || mem_we !== 1'b1 || mem_din !== 1'b0)
                    clr_bad++;
                busy_cnt++;
            end
            if (clear_done) begin
                if (done_q.size() == 0) begin
                    fail("clear_done_unexpected", "clear_done seen with nothing expected");
                end else begin
                    m_d = done_q.pop_front();
                    check("clear_done_cycle", cyc, m_d);
                end
                check("clear_busy_cycles", busy_cnt, 256);
                check("clear_sequence_errors", clr_bad, 0);
                check("clear_busy_at_done", clear_busy, 0);
                busy_cnt = 0;
                clr_bad  = 0;
            end
        end
    end

    task automatic wait_gnt(input bit port, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (port ? sb.gnt : hb.gnt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("gnt_timeout", port ? "no solver gnt within 400 cycles" : "no host gnt within 400 cycles");
    endtask

    task automatic expect_gnt(input bit port, input bit we, input logic [3:0] x, input logic [3:0] y,
                              input bit din, input int at);
        gnt_t g;
        g.port = port; g.we = we; g.din = din; g.err = 1'b0; g.x = x; g.y = y; g.cyc = at;
        gnt_q.push_back(g);
    endtask

    task automatic expect_rv(input bit port, input bit data, input int at);
        rv_t r;
        r.port = port; r.data = data; r.cyc = at;
        rv_q.push_back(r);
    endtask

    // Single access on dut; called on a falling edge with the arbiter idle.
    task automatic op(input bit port, input bit we, input logic [3:0] x, input logic [3:0] y,
                      input bit din, input bit exp_rd, input int lat);
        bit ok;
        expect_gnt(port, we, x, y, din, cyc + lat);
        if (!we) expect_rv(port, exp_rd, cyc + lat + 1);
        if (port) begin
            sb.req = 1'b1; sb.we = we; sb.x = x; sb.y = y; sb.din = din;
        end else begin
            hb.req = 1'b1; hb.we = we; hb.x = x; hb.y = y; hb.din = din;
        end
        wait_gnt(port, ok);
        if (port) sb.req = 1'b0;
        else      hb.req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic op2(input bit we, input logic [3:0] x, input logic [3:0] y, input bit din,
                       input bit exp_err, input bit exp_rd);
        hb2.req = 1'b1; hb2.we = we; hb2.x = x; hb2.y = y; hb2.din = din;
        @(negedge clk);
        check("n10_gnt", hb2.gnt, 1);
        check("n10_err", err2, exp_err);
        check("n10_mem_we", mem_we2, we & ~exp_err);
        hb2.req = 1'b0;
        @(negedge clk);
        check("n10_rvalid", hb2.rvalid, !we);
        if (!we) check("n10_rdata", rdata2, exp_rd);
        check("n10_err_single", err2, 0);
        @(negedge clk);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within 20000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int nz;
        bit ok;
        hb.req = 0; hb.we = 0; hb.x = 0; hb.y = 0; hb.din = 0;
        sb.req = 0; sb.we = 0; sb.x = 0; sb.y = 0; sb.din = 0;
        hb2.req = 0; hb2.we = 0; hb2.x = 0; hb2.y = 0; hb2.din = 0;
        sb2.req = 0; sb2.we = 0; sb2.x = 0; sb2.y = 0; sb2.din = 0;
        clear_start = 0;
        clear_start2 = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {rdata, err, clear_busy, clear_done, mem_we, mem_din, mem_x, mem_y,
                                hb.gnt, hb.rvalid, sb.gnt, sb.rvalid}, 0);
        check("reset_outputs_n10", {rdata2, err2, clear_busy2, clear_done2, mem_we2, mem_din2, mem_x2,
                                    mem_y2, hb2.gnt, hb2.rvalid, sb2.gnt, sb2.rvalid}, 0);
        reset = 0;

        // Write then read back through the other port.
        op(0, 1, 3, 5, 1, 0, 1);
        op(1, 0, 3, 5, 0, 1, 1);
        op(0, 1, 15, 15, 1, 0, 1);
        op(1, 0, 15, 15, 0, 1, 1);

        // Both request together, host drops after its grant.
        c = cyc;
        expect_gnt(0, 1, 1, 1, 1, c + 1);
        expect_gnt(1, 1, 2, 2, 1, c + 3);
        hb.req = 1; hb.we = 1; hb.x = 1; hb.y = 1; hb.din = 1;
        sb.req = 1; sb.we = 1; sb.x = 2; sb.y = 2; sb.din = 1;
        wait_gnt(0, ok);
        hb.req = 0;
        wait_gnt(1, ok);
        sb.req = 0;
        repeat (2) @(negedge clk);

        // Both request together, host follows with a second write.
        c = cyc;
        hb.req = 1; hb.we = 1; hb.x = 1; hb.y = 1; hb.din = 1;
        sb.req = 1; sb.we = 1; sb.x = 2; sb.y = 2; sb.din = 1;
`ifdef ARB_RR_EN
        expect_gnt(0, 1, 1, 1, 1, c + 1);
        expect_gnt(1, 1, 2, 2, 1, c + 3);
        expect_gnt(0, 1, 4, 4, 1, c + 5);
        wait_gnt(0, ok);
        hb.x = 4; hb.y = 4;
        wait_gnt(1, ok);
        sb.req = 0;
        wait_gnt(0, ok);
        hb.req = 0;
`else
        expect_gnt(0, 1, 1, 1, 1, c + 1);
        expect_gnt(0, 1, 4, 4, 1, c + 3);
        expect_gnt(1, 1, 2, 2, 1, c + 5);
        wait_gnt(0, ok);
        hb.x = 4; hb.y = 4;
        wait_gnt(0, ok);
        hb.req = 0;
        wait_gnt(1, ok);
        sb.req = 0;
`endif
        repeat (2) @(negedge clk);

        // Full clear; solver read of (15,15) arrives at clear cycle 10 and is held off.
        c = cyc;
        done_q.push_back(c + 258);
        clear_start = 1;
        @(negedge clk);
        clear_start = 0;
        repeat (11) @(negedge clk);
        op(1, 0, 15, 15, 0, 0, 247);
        nz = 0;
        for (int i = 0; i < 256; i++) if (mem1[i] !== 1'b0) nz++;
        check("cells_nonzero_after_clear", nz, 0);

        // Clear requested during a read grant, then reset at clear cycle 50.
        c = cyc;
        expect_gnt(0, 0, 3, 5, 0, c + 1);
        expect_rv(0, 0, c + 2);
        hb.req = 1; hb.we = 0; hb.x = 3; hb.y = 5;
        @(negedge clk);
        hb.req = 0;
        clear_start = 1;
        @(negedge clk);
        clear_start = 0;
        repeat (52) @(negedge clk);
        check("busy_at_clear_cycle_50", clear_busy, 1);
        check("addr_at_clear_cycle_50", {mem_y, mem_x}, 8'd50);
        reset = 1;
        @(negedge clk);
        check("outputs_after_mid_reset", {rdata, err, clear_busy, clear_done, mem_we, mem_din, mem_x,
                                          mem_y, hb.gnt, hb.rvalid, sb.gnt, sb.rvalid}, 0);
        reset = 0;
        op(0, 0, 0, 0, 0, 0, 1);

        // Fresh clear restarts from (0,0).
        c = cyc;
        done_q.push_back(c + 258);
        clear_start = 1;
        @(negedge clk);
        clear_start = 0;
        for (int i = 0; i < 300 && done_q.size() != 0; i++) @(negedge clk);

        // N=10 instance: out-of-range read and write, then in-range traffic.
        op2(0, 12, 4, 0, 1, 1);
        op2(1, 3, 10, 1, 1, 0);
        op2(1, 9, 9, 1, 0, 0);
        op2(0, 9, 9, 0, 0, 1);
        op2(0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("gnt_queue_drained", gnt_q.size(), 0);
        check("rv_queue_drained", rv_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
